// File: rtl/controller_pkg.sv
// controller_pkg: shared types for the multicycle RV32I control unit.
//   opcodetype - supported opcodes (instr[6:0])
//   statetype  - main FSM states
//   aluop_t    - main FSM -> ALU decoder operation class
//   aluctl_t   - ALU function select driven to the datapath
//   imm/select - encodings of the datapath mux selects
package controller_pkg;

  typedef enum logic [6:0] {
    OP_LW   = 7'b0000011,
    OP_IALU = 7'b0010011,
    OP_SW   = 7'b0100011,
    OP_R    = 7'b0110011,
    OP_BEQ  = 7'b1100011,
    OP_JAL  = 7'b1101111
  } opcodetype;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BEQ,
    JAL
  } statetype;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [2:0] {
    ALUCTL_ADD = 3'b000,
    ALUCTL_SUB = 3'b001,
    ALUCTL_AND = 3'b010,
    ALUCTL_OR  = 3'b011,
    ALUCTL_SLT = 3'b101
  } aluctl_t;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

endpackage

// File: rtl/controller_if.sv
// controller_if: instruction fields / ALU flag in, datapath controls out.
//   master - the control unit (reads op/funct3/funct7b5/Zero, drives selects/enables)
//   slave  - the datapath (drives op/funct3/funct7b5/Zero, reads selects/enables)
interface controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic [1:0] ImmSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic       AdrSrc;
  logic [2:0] ALUControl;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
           IRWrite, PCWrite, RegWrite, MemWrite
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
           IRWrite, PCWrite, RegWrite, MemWrite
  );
endinterface

// File: rtl/controller_decoders.sv
// Combinational decoders used by the controller.
//   alu_decoder:   ALUOp, funct3, funct7b5, op5 -> ALUControl
//   instr_decoder: op -> ImmSrc (immediate format, valid in every state)
module alu_decoder
  import controller_pkg::*;
(
  input  aluop_t     ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output aluctl_t    ALUControl
);

  always_comb begin
    ALUControl = ALUCTL_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALUCTL_ADD;
      ALUOP_SUB: ALUControl = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type sub from addi, whose instr[30] is immediate data
          3'b000:  ALUControl = (funct7b5 & op5) ? ALUCTL_SUB : ALUCTL_ADD;
          3'b010:  ALUControl = ALUCTL_SLT;
          3'b110:  ALUControl = ALUCTL_OR;
          3'b111:  ALUControl = ALUCTL_AND;
          default: ALUControl = ALUCTL_ADD;
        endcase
      end
      default: ALUControl = ALUCTL_ADD;
    endcase
  end

endmodule

module instr_decoder
  import controller_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] ImmSrc
);

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/controller.sv
// controller: multicycle RV32I (lw, sw, R, I-ALU, beq, jal) control unit.
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset, forces FETCH
//   bus   - controller_if.master: op/funct3/funct7b5/Zero in; ImmSrc,
//           ALUSrcA/B, ResultSrc, AdrSrc, ALUControl, IRWrite, PCWrite,
//           RegWrite, MemWrite out
// Moore main FSM; only PCWrite sees a live input (Zero) for beq.
module controller
  import controller_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  controller_if.master bus
);

  statetype   state, next_state;
  aluop_t     alu_op;
  aluctl_t    alu_ctl;
  logic       branch, pc_update;
  logic [1:0] alusrc_a, alusrc_b, result_src, imm_src;
  logic       adr_src, ir_write, reg_write, mem_write;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    alu_op     = ALUOP_ADD;
    branch     = 1'b0;
    pc_update  = 1'b0;
    alusrc_a   = SRCA_PC;
    alusrc_b   = SRCB_RD2;
    result_src = RES_ALUOUT;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    case (state)
      FETCH: begin
        ir_write   = 1'b1;
        alusrc_b   = SRCB_FOUR;
        result_src = RES_ALURES;
        pc_update  = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        alusrc_a = SRCA_OLDPC;
        alusrc_b = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTER;
          OP_IALU:      next_state = EXECUTEI;
          OP_BEQ:       next_state = BEQ;
          OP_JAL:       next_state = JAL;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR: begin
        alusrc_a   = SRCA_RD1;
        alusrc_b   = SRCB_IMM;
        next_state = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src    = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTER: begin
        alusrc_a   = SRCA_RD1;
        alu_op     = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      EXECUTEI: begin
        alusrc_a   = SRCA_RD1;
        alusrc_b   = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        next_state = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
      end
      BEQ: begin
        alusrc_a = SRCA_RD1;
        alu_op   = ALUOP_SUB;
        branch   = 1'b1;
      end
      JAL: begin
        alusrc_a   = SRCA_OLDPC;
        alusrc_b   = SRCB_FOUR;
        pc_update  = 1'b1;
        next_state = ALUWB;
      end
      default: next_state = FETCH;
    endcase
  end

  alu_decoder u_alu_dec (
    .ALUOp      (alu_op),
    .funct3     (bus.funct3),
    .funct7b5   (bus.funct7b5),
    .op5        (bus.op[5]),
    .ALUControl (alu_ctl)
  );

  instr_decoder u_instr_dec (
    .op     (bus.op),
    .ImmSrc (imm_src)
  );

  assign bus.ImmSrc     = imm_src;
  assign bus.ALUSrcA    = alusrc_a;
  assign bus.ALUSrcB    = alusrc_b;
  assign bus.ResultSrc  = result_src;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUControl = alu_ctl;
  assign bus.IRWrite    = ir_write;
  assign bus.PCWrite    = pc_update | (branch & bus.Zero);
  assign bus.RegWrite   = reg_write;
  assign bus.MemWrite   = mem_write;

endmodule

// File: tb/tb_controller.sv
// tb_controller: randomized instruction stream against a per-cycle model of
// the control word each instruction class should produce, with asynchronous
// resets injected mid-instruction.
module tb_controller;

  logic clk = 1'b0;
  logic reset;

  controller_if bus ();

  controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef enum {K_FETCH, K_DECODE, K_MEMADR, K_MEMREAD, K_MEMWB, K_MEMWRITE,
                K_EXR, K_EXI, K_ALUWB, K_BEQ, K_JAL} kind_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl, IRWrite, PCWrite, RegWrite, MemWrite}
  function automatic logic [15:0] observed();
    return {bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc,
            bus.ALUControl, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (op)
      7'b0100011: return 2'd1;
      7'b1100011: return 2'd2;
      7'b1101111: return 2'd3;
      default:    return 2'd0;
    endcase
  endfunction

  // ALU function an R/I instruction asks for
  function automatic logic [2:0] arith_fn(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (op == 7'b0110011 && f7) ? 3'd1 : 3'd0;
      3'b010:  return 3'd5;
      3'b110:  return 3'd3;
      3'b111:  return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  // cycle sequence each instruction class walks through
  function automatic void steps(input logic [6:0] op, output kind_t q[$]);
    q = {K_FETCH, K_DECODE};
    case (op)
      7'b0000011: q = {q, K_MEMADR, K_MEMREAD, K_MEMWB};
      7'b0100011: q = {q, K_MEMADR, K_MEMWRITE};
      7'b0110011: q = {q, K_EXR, K_ALUWB};
      7'b0010011: q = {q, K_EXI, K_ALUWB};
      7'b1100011: q = {q, K_BEQ};
      7'b1101111: q = {q, K_JAL, K_ALUWB};
      default:    ;
    endcase
  endfunction

  function automatic logic [15:0] expected(input kind_t k, input logic [6:0] op,
                                           input logic [2:0] f3, input logic f7, input logic z);
    logic [1:0] srca = 2'd0, srcb = 2'd0, res = 2'd0;
    logic [2:0] aluc = 3'd0;
    logic adr = 1'b0, irw = 1'b0, pcw = 1'b0, regw = 1'b0, memw = 1'b0;
    case (k)
      K_FETCH:    begin irw = 1; srcb = 2; res = 2; pcw = 1; end
      K_DECODE:   begin srca = 1; srcb = 1; end
      K_MEMADR:   begin srca = 2; srcb = 1; end
      K_MEMREAD:  begin adr = 1; end
      K_MEMWB:    begin res = 1; regw = 1; end
      K_MEMWRITE: begin adr = 1; memw = 1; end
      K_EXR:      begin srca = 2; srcb = 0; aluc = arith_fn(op, f3, f7); end
      K_EXI:      begin srca = 2; srcb = 1; aluc = arith_fn(op, f3, f7); end
      K_ALUWB:    begin regw = 1; end
      K_BEQ:      begin srca = 2; aluc = 3'd1; pcw = z; end
      K_JAL:      begin srca = 1; srcb = 2; pcw = 1; end
      default:    ;
    endcase
    return {imm_of(op), srca, srcb, res, adr, aluc, irw, pcw, regw, memw};
  endfunction

  // Entered and left at a falling edge. zmode: 0/1 fixed Zero, 2 random.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int zmode, input bit allow_rst);
    kind_t q[$];
    int    rst_at;
    steps(op, q);
    rst_at = (allow_rst && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
    for (int s = 0; s < q.size(); s++) begin
      bus.op       = op;
      bus.funct3   = f3;
      bus.funct7b5 = f7;
      bus.Zero     = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      check_eq($sformatf("%s op=%b f3=%b f7=%b z=%b", q[s].name(), op, f3, f7, bus.Zero),
               observed(), expected(q[s], op, f3, f7, bus.Zero));
      if (s == rst_at) begin
        #1 reset = 1'b0;
        #1;
        check_eq("async_reset", observed(), expected(K_FETCH, op, f3, f7, bus.Zero));
        @(posedge clk);
        #1;
        check_eq("reset_hold", observed(), expected(K_FETCH, op, f3, f7, bus.Zero));
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [6:0] rop;
    reset        = 1'b0;
    bus.op       = 7'b0000011;
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b0;
    bus.Zero     = 1'b0;
    #2;
    check_eq("reset_state", observed(), expected(K_FETCH, 7'b0000011, 3'b000, 1'b0, 1'b0));
    @(negedge clk);
    check_eq("reset_state_edge", observed(), expected(K_FETCH, 7'b0000011, 3'b000, 1'b0, 1'b0));
    reset = 1'b1;

    // directed classes
    run_instr(7'b0000011, 3'b010, 1'b0, 2, 1'b0); // lw
    run_instr(7'b0100011, 3'b010, 1'b0, 2, 1'b0); // sw
    run_instr(7'b0110011, 3'b000, 1'b1, 2, 1'b0); // sub
    run_instr(7'b0110011, 3'b000, 1'b0, 2, 1'b0); // add
    run_instr(7'b0110011, 3'b010, 1'b0, 2, 1'b0); // slt
    run_instr(7'b0110011, 3'b110, 1'b0, 2, 1'b0); // or
    run_instr(7'b0110011, 3'b111, 1'b0, 2, 1'b0); // and
    run_instr(7'b0010011, 3'b000, 1'b1, 2, 1'b0); // addi, instr[30]=1
    run_instr(7'b1100011, 3'b000, 1'b0, 1, 1'b0); // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 1'b0); // beq not taken
    run_instr(7'b1101111, 3'b000, 1'b0, 1, 1'b0); // jal
    run_instr(7'b1111111, 3'b000, 1'b0, 2, 1'b0); // unknown opcode

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 6))
        0:       rop = 7'b0000011;
        1:       rop = 7'b0100011;
        2:       rop = 7'b0110011;
        3:       rop = 7'b0010011;
        4:       rop = 7'b1100011;
        5:       rop = 7'b1101111;
        default: rop = 7'($urandom);
      endcase
      run_instr(rop, 3'($urandom), 1'($urandom), 2, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
